pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL power-up sequencer: holds PLL reset, qualifies lock, then
// releases the downstream domain resets one after another.
module pll_reset_sequencer #(
   parameter int NUM_OUT        = 4,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int LOCK_STABLE    = 64,
   parameter int STAGE_GAP      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               restart,
   output logic               pll_rst,
   output logic [NUM_OUT-1:0] rst_out_n,
   output logic               ready,
   output logic [7:0]         lock_loss_cnt,
   output logic [7:0]         timeout_cnt
);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_RELEASE,
      S_RUN
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int REL_CYCLES = STAGE_GAP * (NUM_OUT - 1) + 2;
   localparam int MAXV = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                              max2(LOCK_STABLE, REL_CYCLES));
   localparam int CW = $clog2(MAXV + 1);

   localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               sync1_q, sync1_d;
   logic               sync2_q, sync2_d;
   logic               pll_rst_q, pll_rst_d;
   logic [NUM_OUT-1:0] rst_out_n_q, rst_out_n_d;
   logic               ready_q, ready_d;
   logic [7:0]         ll_cnt_q, ll_cnt_d;
   logic [7:0]         to_cnt_q, to_cnt_d;
   logic               ll_inc, to_inc;
   logic               locked_s;

   assign sync1_d  = pll_locked;
   assign sync2_d  = sync1_q;
   assign locked_s = sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RESET_PLL;
         cnt_q       <= '0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         pll_rst_q   <= 1'b1;
         rst_out_n_q <= '0;
         ready_q     <= 1'b0;
         ll_cnt_q    <= '0;
         to_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         pll_rst_q   <= pll_rst_d;
         rst_out_n_q <= rst_out_n_d;
         ready_q     <= ready_d;
         ll_cnt_q    <= ll_cnt_d;
         to_cnt_q    <= to_cnt_d;
      end
   end

   // restart wins over lock loss and timeout, so it never counts
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ll_inc  = 1'b0;
      to_inc  = 1'b0;
      if (restart) begin
         state_d = S_RESET_PLL;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_RESET_PLL: begin
               if (cnt_q == RST_LAST) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = S_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == TO_LAST) begin
                  state_d = S_RESET_PLL;
                  cnt_d   = '0;
                  to_inc  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_STABLE: begin
               if (!locked_s) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STB_LAST) begin
                  state_d = S_RELEASE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_RELEASE: begin
               if (!locked_s) begin
                  state_d = S_RESET_PLL;
                  cnt_d   = '0;
                  ll_inc  = 1'b1;
               end else if (&rst_out_n_q) begin
                  state_d = S_RUN;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_RUN: begin
               if (!locked_s) begin
                  state_d = S_RESET_PLL;
                  cnt_d   = '0;
                  ll_inc  = 1'b1;
               end
            end
            default: begin
               state_d = S_RESET_PLL;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // outputs are registered from the next state so they track state_q
   always_comb begin
      pll_rst_d   = (state_d == S_RESET_PLL);
      ready_d     = (state_d == S_RUN);
      rst_out_n_d = '0;
      if (state_d == S_RUN) begin
         rst_out_n_d = '1;
      end else if (state_d == S_RELEASE && state_q == S_RELEASE) begin
         for (int i = 0; i < NUM_OUT; i++) begin
            rst_out_n_d[i] = rst_out_n_q[i] |
                             (cnt_q >= CW'(STAGE_GAP * i));
         end
      end
      ll_cnt_d = ll_cnt_q;
      if (ll_inc && ll_cnt_q != 8'hFF) begin
         ll_cnt_d = ll_cnt_q + 8'd1;
      end
      to_cnt_d = to_cnt_q;
      if (to_inc && to_cnt_q != 8'hFF) begin
         to_cnt_d = to_cnt_q + 8'd1;
      end
   end

   assign pll_rst       = pll_rst_q;
   assign rst_out_n     = rst_out_n_q;
   assign ready         = ready_q;
   assign lock_loss_cnt = ll_cnt_q;
   assign timeout_cnt   = to_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: expected output changes are queued
// with their cycle number and checked by an independent monitor.
module tb_pll_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       restart;
   logic       pll_rst;
   logic [3:0] rst_out_n;
   logic       ready;
   logic [7:0] lock_loss_cnt;
   logic [7:0] timeout_cnt;

   pll_reset_sequencer #(
      .NUM_OUT(4),
      .PLL_RST_CYCLES(4),
      .LOCK_TIMEOUT(100),
      .LOCK_STABLE(8),
      .STAGE_GAP(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pll_locked(pll_locked),
      .restart(restart),
      .pll_rst(pll_rst),
      .rst_out_n(rst_out_n),
      .ready(ready),
      .lock_loss_cnt(lock_loss_cnt),
      .timeout_cnt(timeout_cnt)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          c;
      logic [21:0] b;
      string       nm;
   } ev_t;

   ev_t q[$];
   int  checks = 0;
   int  errors = 0;

   logic       e_pr;
   logic [3:0] e_ro;
   logic       e_rd;
   logic [7:0] e_ll;
   logic [7:0] e_to;
   int         t_base;

   localparam logic [21:0] RST_B = {1'b1, 4'b0000, 1'b0, 8'd0, 8'd0};

   function automatic logic [21:0] pack_exp();
      return {e_pr, e_ro, e_rd, e_ll, e_to};
   endfunction

   task automatic exp_at(input int c, input string nm);
      ev_t e;
      e.c  = c;
      e.b  = pack_exp();
      e.nm = nm;
      q.push_back(e);
   endtask

   task automatic set_reset_exp();
      e_pr = 1'b1;
      e_ro = 4'b0000;
      e_rd = 1'b0;
      e_ll = 8'd0;
      e_to = 8'd0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_reset();
      int r0;
      r0         = cyc;
      rst        = 1'b1;
      pll_locked = 1'b0;
      restart    = 1'b0;
      if (pack_exp() != RST_B) begin
         set_reset_exp();
         exp_at(r0 + 1, "reset_values");
      end
      wait_until(r0 + 3);
      rst    = 1'b0;
      t_base = r0 + 3;
      e_pr   = 1'b0;
      exp_at(t_base + 4, "pll_rst_fall");
   endtask

   task automatic exp_release(input int e, input string nm);
      e_ro = 4'b0001; exp_at(e + 1, {nm, "_r0"});
      e_ro = 4'b0011; exp_at(e + 3, {nm, "_r1"});
      e_ro = 4'b0111; exp_at(e + 5, {nm, "_r2"});
      e_ro = 4'b1111; exp_at(e + 7, {nm, "_r3"});
      e_rd = 1'b1;    exp_at(e + 8, {nm, "_ready"});
   endtask

   initial begin : monitor
      logic [21:0] prev;
      logic [21:0] cur;
      ev_t         e;
      prev = 'x;
      forever begin
         @(negedge clk);
         cur = {pll_rst, rst_out_n, ready, lock_loss_cnt, timeout_cnt};
         if (cur !== prev) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cyc=%0d got=%h",
                        cyc, cur);
            end else begin
               e = q.pop_front();
               if (e.c != cyc || e.b !== cur) begin
                  errors++;
                  $display("FAIL %s got cyc=%0d val=%h exp cyc=%0d val=%h",
                           e.nm, cyc, cur, e.c, e.b);
               end
            end
            prev = cur;
         end
      end
   end

   initial begin : watchdog
      #(20 * 60000);
      $display("FAIL watchdog cyc=%0d exp finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int p;
      int d;
      rst        = 1'b1;
      pll_locked = 1'b0;
      restart    = 1'b0;
      set_reset_exp();
      exp_at(1, "reset_values");

      // 1: normal power-up sequence
      e_pr = 1'b0;
      exp_at(9, "pll_rst_fall");
      p = 20;
      exp_release(p + 11, "t1");
      wait_until(5);
      rst = 1'b0;
      wait_until(p);
      pll_locked = 1'b1;
      wait_until(p + 20);

      // 2: lock never arrives, timeouts saturate
      do_reset();
      for (int k = 1; k <= 300; k++) begin
         e_pr = 1'b1;
         e_to = (k > 255) ? 8'd255 : 8'(k);
         exp_at(t_base + 104 * k, "timeout_rise");
         if (k < 300) begin
            e_pr = 1'b0;
            exp_at(t_base + 104 * k + 4, "timeout_fall");
         end
      end
      wait_until(t_base + 104 * 300 + 2);

      // 3: one-cycle glitch during qualification
      do_reset();
      p = t_base + 10;
      exp_release(p + 18, "t3");
      wait_until(p);
      pll_locked = 1'b1;
      wait_until(p + 6);
      pll_locked = 1'b0;
      wait_until(p + 7);
      pll_locked = 1'b1;
      wait_until(p + 30);

      // 4: lock loss in RUN, then relock
      d = cyc;
      pll_locked = 1'b0;
      e_pr = 1'b1; e_ro = 4'b0000; e_rd = 1'b0; e_ll = 8'd1;
      exp_at(d + 3, "lock_loss");
      e_pr = 1'b0;
      exp_at(d + 7, "relock_pll_rst_fall");
      p = d + 10;
      exp_release(p + 11, "t4");
      wait_until(p);
      pll_locked = 1'b1;
      wait_until(p + 24);

      // 5: restart coincides with lock loss
      d = cyc;
      pll_locked = 1'b0;
      e_pr = 1'b1; e_ro = 4'b0000; e_rd = 1'b0;
      exp_at(d + 3, "restart_no_count");
      e_pr = 1'b0;
      exp_at(d + 7, "restart_pll_rst_fall");
      wait_until(d + 2);
      restart = 1'b1;
      wait_until(d + 3);
      restart = 1'b0;
      wait_until(d + 12);

      // 6: rst in the middle of RELEASE
      do_reset();
      p = t_base + 10;
      e_ro = 4'b0001; exp_at(p + 12, "t6_r0");
      e_ro = 4'b0011; exp_at(p + 14, "t6_r1");
      wait_until(p);
      pll_locked = 1'b1;
      wait_until(p + 14);
      rst        = 1'b1;
      pll_locked = 1'b0;
      set_reset_exp();
      exp_at(p + 15, "rst_in_release");
      wait_until(p + 17);
      rst    = 1'b0;
      t_base = p + 17;
      e_pr   = 1'b0;
      exp_at(t_base + 4, "pll_rst_fall");
      wait_until(t_base + 10);
      @(negedge clk);

      while (q.size() > 0) begin
         ev_t e;
         e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s missing exp cyc=%0d val=%h", e.nm, e.c, e.b);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
